// File: rtl/diff_demo_pkg.sv
// Shared definitions for the diff core's buffer-scheduling logic.
//   bank_state_e : life cycle of one feature-map/guard bank
//   top_state_e  : job-level state of the bank scheduler
//   CONF_NUM_FM_BANKS : number of ping-pong banks (ping = 0, pong = 1)
package diff_demo_pkg;

    localparam int CONF_NUM_FM_BANKS = 2;

    typedef enum logic [1:0] {
        BANK_EMPTY     = 2'd0,
        BANK_LOADING   = 2'd1,
        BANK_FULL      = 2'd2,
        BANK_COMPUTING = 2'd3
    } bank_state_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } top_state_e;

endpackage

// File: rtl/fm_bank_scheduler_bank_state_tracker.sv
// bank_state_tracker: state of a single ping-pong bank.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr_i       : return to EMPTY (job accept); dominates all events
//   start_i     : loader claimed this bank       (EMPTY     -> LOADING)
//   done_i      : loader filled this bank        (LOADING   -> FULL)
//   issue_i     : core accepted this bank        (FULL      -> COMPUTING)
//   finish_i    : core released this bank        (COMPUTING -> EMPTY)
//   state_o     : current bank state
// An event that does not match the current state is ignored; the top
// decides which events are legal and flags protocol errors.
module bank_state_tracker
    import diff_demo_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        start_i,
    input  logic        done_i,
    input  logic        issue_i,
    input  logic        finish_i,
    output bank_state_e state_o
);

    bank_state_e state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BANK_EMPTY;
        end else if (clr_i) begin
            state_q <= BANK_EMPTY;
        end else begin
            case (state_q)
                BANK_EMPTY:     if (start_i)  state_q <= BANK_LOADING;
                BANK_LOADING:   if (done_i)   state_q <= BANK_FULL;
                BANK_FULL:      if (issue_i)  state_q <= BANK_COMPUTING;
                BANK_COMPUTING: if (finish_i) state_q <= BANK_EMPTY;
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/fm_bank_scheduler.sv
// fm_bank_scheduler: ping-pong bank scheduler between the feature-map
// loader and the diff core, so loading layer N+1 overlaps computing layer N.
//   cfg_valid/cfg_ready/cfg_layer_num : job start handshake and layer count
//   load_ready/load_bank/load_start/load_done : loader side
//   core_valid/core_ready/core_bank/core_finish : core start handshake
//   layers_done : layers finished in the current job
//   job_done    : one-cycle pulse after the last layer finishes
//   err         : sticky protocol error, cleared at job accept
// Every output is decoded from registered state only; no input reaches an
// output combinationally.
module fm_bank_scheduler
    import diff_demo_pkg::*;
#(
    parameter int NUM_BANKS = CONF_NUM_FM_BANKS,
    parameter int LAYER_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [LAYER_W-1:0] cfg_layer_num,
    output logic               load_ready,
    output logic               load_bank,
    input  logic               load_start,
    input  logic               load_done,
    output logic               core_valid,
    input  logic               core_ready,
    output logic               core_bank,
    input  logic               core_finish,
    output logic [LAYER_W-1:0] layers_done,
    output logic               job_done,
    output logic               err
);

    top_state_e         state_q;
    logic [LAYER_W-1:0] layer_num_q;
    logic [LAYER_W-1:0] loads_issued_q;
    logic [LAYER_W-1:0] loads_issued_d;
    logic [LAYER_W-1:0] layers_done_q;
    logic [LAYER_W-1:0] layers_done_d;
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic               err_q;
    logic               err_d;

    bank_state_e        bank_state [NUM_BANKS];
    logic [NUM_BANKS-1:0] is_loading;
    logic [NUM_BANKS-1:0] is_computing;
    logic [NUM_BANKS-1:0] start_vec;
    logic [NUM_BANKS-1:0] done_vec;
    logic [NUM_BANKS-1:0] issue_vec;
    logic [NUM_BANKS-1:0] finish_vec;

    logic run;
    logic cfg_fire;
    logic load_fire;
    logic issue_fire;
    logic done_fire;
    logic finish_fire;
    logic any_loading;
    logic any_computing;

    assign run           = (state_q == ST_RUN);
    assign cfg_fire      = cfg_valid && (state_q == ST_IDLE);
    assign any_loading   = |is_loading;
    assign any_computing = |is_computing;

    // Only one bank may be in flight on each side, which is what keeps the
    // bank order strictly alternating and load_done/core_finish unambiguous.
    assign load_ready = run && (bank_state[wr_ptr_q] == BANK_EMPTY) && !any_loading
                        && (loads_issued_q < layer_num_q);
    assign core_valid = run && (bank_state[rd_ptr_q] == BANK_FULL) && !any_computing;

    assign load_fire   = load_start && load_ready;
    assign issue_fire  = core_valid && core_ready;
    assign done_fire   = load_done && any_loading;
    assign finish_fire = core_finish && any_computing;

    assign loads_issued_d = loads_issued_q + LAYER_W'(1);
    assign layers_done_d  = layers_done_q + LAYER_W'(1);

    // Illegal pulses only set the sticky flag; the event itself is dropped.
    assign err_d = cfg_fire ? 1'b0
                 : (err_q || (load_start && !load_ready)
                          || (load_done && !any_loading)
                          || (core_finish && !any_computing));

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            assign is_loading[gi]   = (bank_state[gi] == BANK_LOADING);
            assign is_computing[gi] = (bank_state[gi] == BANK_COMPUTING);
            assign start_vec[gi]    = load_fire  && (wr_ptr_q == 1'(gi));
            assign done_vec[gi]     = done_fire  && is_loading[gi];
            assign issue_vec[gi]    = issue_fire && (rd_ptr_q == 1'(gi));
            assign finish_vec[gi]   = finish_fire && is_computing[gi];

            bank_state_tracker u_tracker (
                .clk      (clk),
                .rst_n    (rst_n),
                .clr_i    (cfg_fire),
                .start_i  (start_vec[gi]),
                .done_i   (done_vec[gi]),
                .issue_i  (issue_vec[gi]),
                .finish_i (finish_vec[gi]),
                .state_o  (bank_state[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            layer_num_q    <= '0;
            loads_issued_q <= '0;
            layers_done_q  <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            err_q <= err_d;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        state_q        <= ST_RUN;
                        // A zero-layer job still runs one layer.
                        layer_num_q    <= (cfg_layer_num == '0) ? LAYER_W'(1) : cfg_layer_num;
                        loads_issued_q <= '0;
                        layers_done_q  <= '0;
                        wr_ptr_q       <= 1'b0;
                        rd_ptr_q       <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (load_fire) begin
                        wr_ptr_q       <= ~wr_ptr_q;
                        loads_issued_q <= loads_issued_d;
                    end
                    if (issue_fire) begin
                        rd_ptr_q <= ~rd_ptr_q;
                    end
                    // Leave RUN on the same edge as the last finish so that
                    // job_done appears in the very next cycle.
                    if (finish_fire) begin
                        layers_done_q <= layers_done_d;
                        if (layers_done_d == layer_num_q) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cfg_ready   = (state_q == ST_IDLE);
    assign job_done    = (state_q == ST_DONE);
    assign load_bank   = wr_ptr_q;
    assign core_bank   = rd_ptr_q;
    assign layers_done = layers_done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_fm_bank_scheduler.sv
module tb_fm_bank_scheduler;

    logic       clk;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_layer_num;
    logic       load_ready;
    logic       load_bank;
    logic       load_start;
    logic       load_done;
    logic       core_valid;
    logic       core_ready;
    logic       core_bank;
    logic       core_finish;
    logic [7:0] layers_done;
    logic       job_done;
    logic       err;

    int checks   = 0;
    int failures = 0;

    fm_bank_scheduler #(.NUM_BANKS(2), .LAYER_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_layer_num (cfg_layer_num),
        .load_ready    (load_ready),
        .load_bank     (load_bank),
        .load_start    (load_start),
        .load_done     (load_done),
        .core_valid    (core_valid),
        .core_ready    (core_ready),
        .core_bank     (core_bank),
        .core_finish   (core_finish),
        .layers_done   (layers_done),
        .job_done      (job_done),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: job progress as counters, banks as "who holds what".
    // Loads go to bank (loads mod 2), core takes the oldest full bank.
    int m_mode;       // 0 idle, 1 run, 2 done
    int m_n, m_loads, m_issues, m_fin;
    int m_loading;    // bank being loaded, -1 none
    int m_computing;  // bank being computed, -1 none
    int m_full[$];    // filled banks in load order
    bit m_err;

    function automatic void model_reset();
        m_mode = 0; m_n = 0; m_loads = 0; m_issues = 0; m_fin = 0;
        m_loading = -1; m_computing = -1; m_full.delete(); m_err = 0;
    endfunction

    function automatic bit m_busy(int b);
        if (m_loading == b || m_computing == b) return 1'b1;
        foreach (m_full[i]) if (m_full[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_load_ready();
        return (m_mode == 1) && (m_loading < 0) && (m_loads < m_n) && !m_busy(m_loads % 2);
    endfunction

    function automatic bit m_core_valid();
        return (m_mode == 1) && (m_computing < 0) && (m_full.size() > 0)
               && (m_full[0] == m_issues % 2);
    endfunction

    function automatic void model_step();
        bit lr, cv;
        int pre_loading, pre_comp;
        if (!rst_n) begin
            model_reset();
            return;
        end
        lr = m_load_ready();
        cv = m_core_valid();
        pre_loading = m_loading;
        pre_comp = m_computing;
        if (m_mode == 0 && cfg_valid) begin
            m_mode = 1;
            m_n = (cfg_layer_num == 0) ? 1 : int'(cfg_layer_num);
            m_loads = 0; m_issues = 0; m_fin = 0;
            m_loading = -1; m_computing = -1; m_full.delete(); m_err = 0;
            return;
        end
        if (load_start && !lr) m_err = 1;
        if (load_done && pre_loading < 0) m_err = 1;
        if (core_finish && pre_comp < 0) m_err = 1;
        if (m_mode == 2) begin
            m_mode = 0;
            return;
        end
        if (m_mode == 1) begin
            if (cv && core_ready) begin
                m_computing = m_full.pop_front();
                m_issues++;
            end
            if (load_done && pre_loading >= 0) begin
                m_full.push_back(pre_loading);
                m_loading = -1;
            end
            if (load_start && lr) begin
                m_loading = m_loads % 2;
                m_loads++;
            end
            if (core_finish && pre_comp >= 0) begin
                m_computing = -1;
                m_fin++;
                if (m_fin == m_n) m_mode = 2;
            end
        end
    endfunction

    // One clock: model follows the edge, outputs are then sampled at negedge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cfg_valid = 1'b0; load_start = 1'b0; load_done = 1'b0;
        core_ready = 1'b0; core_finish = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({cfg_ready, load_ready, load_bank, core_valid, core_bank, job_done, err} !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_ctl: got %b expected %b",
                {cfg_ready, load_ready, load_bank, core_valid, core_bank, job_done, err}, 7'b1000000);
        end
        checks++;
        if (layers_done !== 8'd0) begin
            failures++;
            $display("FAIL reset_layers: got %0d expected 0", layers_done);
        end
        $display("reset: cfg_ready=%b layers_done=%0d", cfg_ready, layers_done);
    endtask

    task automatic test_single_layer();
        cfg_valid = 1'b1; cfg_layer_num = 8'd1; tick();
        checks++;
        if ({cfg_ready, load_ready, load_bank} !== 3'b010) begin
            failures++;
            $display("FAIL single_accept: got %b expected 010", {cfg_ready, load_ready, load_bank});
        end
        load_start = 1'b1; tick();
        load_done = 1'b1; tick();
        checks++;
        if ({core_valid, core_bank, load_ready} !== 3'b100) begin
            failures++;
            $display("FAIL single_core_valid: got %b expected 100", {core_valid, core_bank, load_ready});
        end
        core_ready = 1'b1; tick();
        core_finish = 1'b1; tick();
        checks++;
        if ({job_done, load_ready, core_valid, layers_done} !== {3'b100, 8'd1}) begin
            failures++;
            $display("FAIL single_job_done: got %b/%0d expected 100/1",
                {job_done, load_ready, core_valid}, layers_done);
        end
        tick();
        checks++;
        if ({cfg_ready, job_done, load_ready} !== 3'b100) begin
            failures++;
            $display("FAIL single_cfg_ready: got %b expected 100", {cfg_ready, job_done, load_ready});
        end
        $display("single_layer: layers_done=%0d cfg_ready=%b", layers_done, cfg_ready);
    endtask

    task automatic test_overlap();
        cfg_valid = 1'b1; cfg_layer_num = 8'd3; tick();
        load_start = 1'b1; tick();
        load_done = 1'b1; tick();
        checks++;
        if ({core_valid, core_bank, load_ready, load_bank} !== 4'b1011) begin
            failures++;
            $display("FAIL overlap_bank0_ready: got %b expected 1011",
                {core_valid, core_bank, load_ready, load_bank});
        end
        core_ready = 1'b1; load_start = 1'b1; tick();
        load_done = 1'b1; tick();
        checks++;
        if ({core_valid, core_bank, load_ready} !== 3'b010) begin
            failures++;
            $display("FAIL overlap_wait_core: got %b expected 010", {core_valid, core_bank, load_ready});
        end
        core_finish = 1'b1; tick();
        checks++;
        if ({core_valid, core_bank, load_ready, load_bank, layers_done} !== {4'b1110, 8'd1}) begin
            failures++;
            $display("FAIL overlap_bank1: got %b/%0d expected 1110/1",
                {core_valid, core_bank, load_ready, load_bank}, layers_done);
        end
        core_ready = 1'b1; load_start = 1'b1; tick();
        load_done = 1'b1; tick();
        core_finish = 1'b1; tick();
        checks++;
        if ({core_valid, core_bank, load_ready, layers_done} !== {3'b100, 8'd2}) begin
            failures++;
            $display("FAIL overlap_third_bank0: got %b/%0d expected 100/2",
                {core_valid, core_bank, load_ready}, layers_done);
        end
        core_ready = 1'b1; tick();
        core_finish = 1'b1; tick();
        checks++;
        if ({job_done, layers_done} !== {1'b1, 8'd3}) begin
            failures++;
            $display("FAIL overlap_done: got %b/%0d expected 1/3", job_done, layers_done);
        end
        tick();
        $display("overlap: layers_done=%0d", layers_done);
    endtask

    task automatic test_same_cycle();
        cfg_valid = 1'b1; cfg_layer_num = 8'd3; tick();
        load_start = 1'b1; tick();
        load_done = 1'b1; tick();
        core_ready = 1'b1; load_start = 1'b1; tick();
        load_done = 1'b1; core_finish = 1'b1; tick();
        checks++;
        if ({core_valid, core_bank, load_ready, load_bank, err} !== 5'b11100) begin
            failures++;
            $display("FAIL same_cycle: got %b expected 11100",
                {core_valid, core_bank, load_ready, load_bank, err});
        end
        core_ready = 1'b1; load_start = 1'b1; tick();
        load_done = 1'b1; tick();
        core_finish = 1'b1; tick();
        core_ready = 1'b1; tick();
        core_finish = 1'b1; tick();
        checks++;
        if ({job_done, layers_done} !== {1'b1, 8'd3}) begin
            failures++;
            $display("FAIL same_cycle_done: got %b/%0d expected 1/3", job_done, layers_done);
        end
        tick();
        $display("same_cycle: layers_done=%0d", layers_done);
    endtask

    task automatic test_slow_core();
        cfg_valid = 1'b1; cfg_layer_num = 8'd1; tick();
        load_start = 1'b1; tick();
        load_done = 1'b1; tick();
        for (int i = 0; i < 10; i++) begin
            core_ready = 1'b0; tick();
            checks++;
            if ({core_valid, core_bank} !== 2'b10) begin
                failures++;
                $display("FAIL slow_hold[%0d]: got %b expected 10", i, {core_valid, core_bank});
            end
        end
        core_ready = 1'b1; tick();
        checks++;
        if (core_valid !== 1'b0) begin
            failures++;
            $display("FAIL slow_handshake: got %b expected 0", core_valid);
        end
        core_finish = 1'b1; tick();
        tick();
        $display("slow_core: handshake after 10 stall cycles");
    endtask

    task automatic test_protocol_err();
        cfg_valid = 1'b1; cfg_layer_num = 8'd2; tick();
        load_done = 1'b1; tick();
        checks++;
        if ({err, load_ready, load_bank, core_valid} !== 4'b1100) begin
            failures++;
            $display("FAIL err_load_done: got %b expected 1100", {err, load_ready, load_bank, core_valid});
        end
        load_start = 1'b1; tick();
        load_done = 1'b1; tick();
        core_ready = 1'b1; load_start = 1'b1; tick();
        load_done = 1'b1; tick();
        core_finish = 1'b1; tick();
        core_ready = 1'b1; tick();
        core_finish = 1'b1; tick();
        checks++;
        if ({job_done, err} !== 2'b11) begin
            failures++;
            $display("FAIL err_sticky: got %b expected 11", {job_done, err});
        end
        tick();
        cfg_valid = 1'b1; cfg_layer_num = 8'd1; tick();
        checks++;
        if ({cfg_ready, err, load_ready} !== 3'b001) begin
            failures++;
            $display("FAIL err_clear: got %b expected 001", {cfg_ready, err, load_ready});
        end
        core_finish = 1'b1; tick();
        checks++;
        if ({err, load_ready, core_valid} !== 3'b110) begin
            failures++;
            $display("FAIL err_core_finish: got %b expected 110", {err, load_ready, core_valid});
        end
        $display("protocol_err: err=%b", err);
    endtask

    task automatic test_reset_mid_job();
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        cfg_valid = 1'b1; cfg_layer_num = 8'd2; tick();
        load_start = 1'b1; tick();
        load_done = 1'b1; tick();
        core_ready = 1'b1; load_start = 1'b1; tick();
        load_done = 1'b1; tick();
        checks++;
        if ({core_valid, core_bank, load_ready} !== 3'b010) begin
            failures++;
            $display("FAIL midjob_setup: got %b expected 010", {core_valid, core_bank, load_ready});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cfg_ready, load_ready, load_bank, core_valid, core_bank, job_done, err, layers_done}
                !== {7'b1000000, 8'd0}) begin
            failures++;
            $display("FAIL midjob_reset: got %b/%0d expected 1000000/0",
                {cfg_ready, load_ready, load_bank, core_valid, core_bank, job_done, err}, layers_done);
        end
        tick();
        rst_n = 1'b1;
        cfg_valid = 1'b1; cfg_layer_num = 8'd2; tick();
        checks++;
        if ({load_ready, load_bank, err} !== 3'b100) begin
            failures++;
            $display("FAIL midjob_restart: got %b expected 100", {load_ready, load_bank, err});
        end
        load_start = 1'b1; tick();
        load_done = 1'b1; tick();
        checks++;
        if ({core_valid, core_bank} !== 2'b10) begin
            failures++;
            $display("FAIL midjob_first_bank: got %b expected 10", {core_valid, core_bank});
        end
        core_ready = 1'b1; load_start = 1'b1; tick();
        load_done = 1'b1; tick();
        core_finish = 1'b1; tick();
        checks++;
        if ({core_valid, core_bank, layers_done} !== {2'b11, 8'd1}) begin
            failures++;
            $display("FAIL midjob_second_bank: got %b/%0d expected 11/1", {core_valid, core_bank}, layers_done);
        end
        core_ready = 1'b1; tick();
        core_finish = 1'b1; tick();
        checks++;
        if ({job_done, err, layers_done} !== {2'b10, 8'd2}) begin
            failures++;
            $display("FAIL midjob_done: got %b/%0d expected 10/2", {job_done, err}, layers_done);
        end
        tick();
        $display("reset_mid_job: restart job layers_done=%0d", layers_done);
    endtask

    task automatic test_random();
        logic [6:0] exp_ctl;
        logic [6:0] got_ctl;
        int jobs = 0;
        for (int c = 0; c < 4000; c++) begin
            exp_ctl = {m_mode == 0, m_load_ready(), 1'(m_loads % 2), m_core_valid(),
                       1'(m_issues % 2), m_mode == 2, m_err};
            got_ctl = {cfg_ready, load_ready, load_bank, core_valid, core_bank, job_done, err};
            checks++;
            if (got_ctl !== exp_ctl) begin
                failures++;
                $display("FAIL random_ctl cycle %0d: got %b expected %b", c, got_ctl, exp_ctl);
            end
            checks++;
            if (layers_done !== 8'(m_fin)) begin
                failures++;
                $display("FAIL random_layers cycle %0d: got %0d expected %0d", c, layers_done, m_fin);
            end
            if (m_mode == 2) begin
                jobs++;
                $display("random job %0d done: layers=%0d err=%b", jobs, m_fin, m_err);
            end
            cfg_valid     = (m_mode == 0) ? ($urandom % 2 == 0) : ($urandom % 12 == 0);
            cfg_layer_num = 8'($urandom_range(0, 5));
            load_start    = m_load_ready() ? ($urandom % 2 == 0) : ($urandom % 40 == 0);
            load_done     = (m_loading >= 0) ? ($urandom % 3 == 0) : ($urandom % 40 == 0);
            core_ready    = ($urandom % 2 == 0);
            core_finish   = (m_computing >= 0) ? ($urandom % 3 == 0) : ($urandom % 40 == 0);
            tick();
        end
        checks++;
        if (jobs < 5) begin
            failures++;
            $display("FAIL random_progress: got %0d jobs expected at least 5", jobs);
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_layer_num = 8'd0;
        load_start = 1'b0; load_done = 1'b0; core_ready = 1'b0; core_finish = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        test_reset();
        test_single_layer();
        test_overlap();
        test_same_cycle();
        test_slow_core();
        test_protocol_err();
        test_reset_mid_job();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fm_bank_scheduler.md
# fm_bank_scheduler

Ping-pong bank scheduler for the feature-map and guard buffers of one diff core. It decides which bank the external loader may fill and which filled bank the core may consume, so that loading layer N+1 overlaps computing layer N. It sits between the DMA/loader front end and the core's start handshake, which is `core_valid` / `core_ready` / `core_finish` / `core_fm_ping_pong_i`. It counts layers and signals completion of a configured job.

## Interface
Parameters:
- `NUM_BANKS`, default 2: bank count; the design is fixed at 2 (ping = 0, pong = 1).
- `LAYER_W`, default 8: width of the layer counters.

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock
- `rst_n`  in  1  async active-low reset
- `cfg_valid`  in  1  job start request
- `cfg_ready`  out  1  scheduler idle, job accepted on `cfg_valid && cfg_ready`
- `cfg_layer_num`  in  LAYER_W  layers in job; sampled at accept; 0 is treated as 1
- `load_ready`  out  1  an EMPTY bank is available and layers remain to load
- `load_bank`  out  1  bank the loader must use, i.e. `load_fm_ping_pong` / `load_gd_ping_pong`
- `load_start`  in  1  loader claims `load_bank`; accepted only with `load_ready`
- `load_done`  in  1  pulse: the bank being loaded is full
- `core_valid`  out  1  to core: a FULL bank is ready to compute
- `core_ready`  in  1  from core
- `core_bank`  out  1  to `core_fm_ping_pong_i`; stable while `core_valid`
- `core_finish`  in  1  pulse: core done with the active bank
- `layers_done`  out  LAYER_W  core_finish count for the current job
- `job_done`  out  1  one-cycle pulse after the last layer finishes
- `err`  out  1  sticky protocol error; cleared only at job accept

## Operation
- Top FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on cfg handshake. At that point: latch the layer count, clear counters, set all banks EMPTY, set `wr_ptr = rd_ptr = 0`, clear `err`.
  - RUN → DONE when `layers_done` reaches the latched count.
  - DONE → IDLE unconditionally after one cycle. `job_done` = 1 in DONE.
- Each bank has a 2-bit state: EMPTY → LOADING → FULL → COMPUTING → EMPTY.
  - EMPTY → LOADING: `load_start && load_ready` for bank `wr_ptr`. Then `wr_ptr` toggles and `loads_issued` increments.
  - LOADING → FULL: `load_done`. This applies to the oldest LOADING bank; at most one bank is LOADING at a time.
  - FULL → COMPUTING: `core_valid && core_ready` on bank `rd_ptr`. Then `rd_ptr` toggles.
  - COMPUTING → EMPTY: `core_finish`. Then `layers_done` increments.
- `load_ready` = RUN && bank[`wr_ptr`] == EMPTY && no bank LOADING && `loads_issued` < layer count.
- `load_bank` = `wr_ptr`.
- `core_valid` = RUN && bank[`rd_ptr`] == FULL && no bank COMPUTING.
- `core_bank` = `rd_ptr`.
- Simultaneous events in one cycle are all applied, because they target distinct banks: `load_start` and `core_finish` on the same bank cannot coincide. Transitions are computed from the pre-edge state.
- Protocol errors set `err` and are otherwise ignored (no state change):
  - `load_start` without `load_ready`
  - `load_done` with no LOADING bank
  - `core_finish` with no COMPUTING bank
- `cfg_valid` outside IDLE is ignored and does not set `err`.

## Timing
- Reset values:
  - `cfg_ready` = 1; all other outputs 0.
  - `load_bank` = `core_bank` = 0, `layers_done` = 0.
  - FSM = IDLE, banks EMPTY.
- All outputs are registered (state-derived); none is combinational from an input.
- Latencies:
  - cfg accept → `load_ready` high the next cycle.
  - `load_done` at edge t → `core_valid` high in cycle t+1 if the core is idle.
  - `core_finish` at edge t → that bank's `load_ready` in t+1.
  - Last `core_finish` → `job_done` in t+1 → `cfg_ready` in t+2.
- `core_valid` stays high until handshaken; `core_bank` does not change while it is high.
- Reset asserted mid-job: everything returns to reset values immediately. In-flight load/finish pulses are lost; no `job_done` is produced.

## Structure
- Shared package `diff_demo_pkg` holds:
  - the bank-state enum (`BANK_EMPTY`, `BANK_LOADING`, `BANK_FULL`, `BANK_COMPUTING`)
  - the top-state enum
  - `CONF_NUM_FM_BANKS = 2`
- One natural sub-module: `bank_state_tracker`, instantiated once per bank. It holds the 2-bit bank state with start/done/issue/finish event inputs and exposes the state. The top holds the pointers, counters and FSM. Expected size is about 200 lines total.

## Test plan
- Single layer: cfg num=1 → `load_bank` = 0, load_start, load_done → `core_valid` with `core_bank` = 0 → core_finish → `job_done` pulse, `layers_done` = 1, `cfg_ready` returns; no second `load_ready`.
- Overlap, num=3:
  - Bank 0 loading completes, then core computes bank 0 while `load_ready` shows bank 1.
  - Load bank 1 while core busy; `core_valid` for bank 1 must wait for core_finish of bank 0.
  - Bank order is 0, 1, 0; `layers_done` = 3.
- Same-cycle events: `load_done`(bank 1) and `core_finish`(bank 0) in the same cycle → next cycle `core_valid` with `core_bank` = 1 and `load_ready` with `load_bank` = 0.
- Slow core: `core_ready` = 0 for 10 cycles with a FULL bank → `core_valid` and `core_bank` held constant; handshake on cycle 11.
- Protocol errors:
  - `load_done` while idle-in-RUN → `err` = 1, bank states unchanged.
  - New cfg accept → `err` = 0.
- Reset mid-job: `rst_n` low while bank 0 is COMPUTING and bank 1 is FULL → all outputs zero, `cfg_ready` = 1; a new job of num=2 runs cleanly from bank 0.
